// File: rtl/cursor_nav.sv
// cursor_nav: board cursor that moves along a row or column, skipping over
// occupied cells one per cycle, and reports a selection on confirm.
// Optional feature: define CURSOR_WRAP_EN to let moves wrap around board edges.
module cursor_nav #(
  parameter int ROWS   = 5,
  parameter int COLS   = 5,
  parameter int CELL_W = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ROWS*COLS*CELL_W-1:0] board,
  input  logic                        move_h,
  input  logic                        move_v,
  input  logic                        direction,
  input  logic                        confirm,
  output logic [$clog2(ROWS)-1:0]     cur_row,
  output logic [$clog2(COLS)-1:0]     cur_col,
  output logic                        busy,
  output logic                        moved,
  output logic                        blocked,
  output logic                        sel_valid,
  output logic [$clog2(ROWS)-1:0]     sel_row,
  output logic [$clog2(COLS)-1:0]     sel_col
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int BW = ROWS * COLS * CELL_W;
  localparam int IW = $clog2(BW);
  localparam logic [RW-1:0] RMAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] CMAX = CW'(COLS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state_q;
  logic          armed_q, mh_q, mv_q, cf_q;
  logic [RW-1:0] cur_row_q, cand_row_q, sel_row_q;
  logic [CW-1:0] cur_col_q, cand_col_q, sel_col_q;
  logic          axis_h_q, dir_q;
  logic          moved_q, blocked_q, sel_valid_q;
`ifdef CURSOR_WRAP_EN
  // Index of the candidate currently under examination (first candidate = 1).
  logic [4:0]    cnt_q;
`endif

  logic          scan, edge_h, edge_v, edge_c, ax_h, dir_s;
  logic [RW-1:0] src_row, nxt_row, nb_row_d;
  logic [CW-1:0] src_col, nxt_col, nb_col_d;
  logic          at_row, at_col, no_nb, stop_d, cand_empty, cur_empty;

  function automatic logic cell_empty(input logic [BW-1:0] b,
                                      input logic [RW-1:0] r,
                                      input logic [CW-1:0] c);
    logic [IW-1:0] idx;
    idx = IW'((int'(r) * COLS + int'(c)) * CELL_W);
    return b[idx +: CELL_W] == '0;
  endfunction

  // Edge detection and next-cell stepping, shared by the IDLE launch and SCAN advance.
  always_comb begin
    scan    = (state_q == SCAN);
    edge_h  = armed_q & move_h  & ~mh_q;
    edge_v  = armed_q & move_v  & ~mv_q;
    edge_c  = armed_q & confirm & ~cf_q;
    ax_h    = scan ? axis_h_q : edge_h;
    dir_s   = scan ? dir_q : direction;
    src_row = scan ? cand_row_q : cur_row_q;
    src_col = scan ? cand_col_q : cur_col_q;
    at_row  = dir_s ? (src_row == RMAX) : (src_row == '0);
    at_col  = dir_s ? (src_col == CMAX) : (src_col == '0);
    if (at_row)     nxt_row = dir_s ? '0 : RMAX;
    else if (dir_s) nxt_row = src_row + 1'b1;
    else            nxt_row = src_row - 1'b1;
    if (at_col)     nxt_col = dir_s ? '0 : CMAX;
    else if (dir_s) nxt_col = src_col + 1'b1;
    else            nxt_col = src_col - 1'b1;
    nb_row_d = ax_h ? src_row : nxt_row;
    nb_col_d = ax_h ? nxt_col : src_col;
`ifdef CURSOR_WRAP_EN
    // With wrap there is always a neighbour; a scan gives up once every
    // other cell on the line has been examined.
    no_nb  = 1'b0;
    stop_d = (cnt_q == (axis_h_q ? 5'(COLS - 1) : 5'(ROWS - 1)));
`else
    no_nb  = ax_h ? at_col : at_row;
    stop_d = no_nb;
`endif
    cand_empty = cell_empty(board, cand_row_q, cand_col_q);
    cur_empty  = cell_empty(board, cur_row_q, cur_col_q);
  end

  // Control FSM: launches scans, walks candidates, and drives registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      mh_q        <= 1'b0;
      mv_q        <= 1'b0;
      cf_q        <= 1'b0;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      cand_row_q  <= '0;
      cand_col_q  <= '0;
      sel_row_q   <= '0;
      sel_col_q   <= '0;
      axis_h_q    <= 1'b0;
      dir_q       <= 1'b0;
      moved_q     <= 1'b0;
      blocked_q   <= 1'b0;
      sel_valid_q <= 1'b0;
`ifdef CURSOR_WRAP_EN
      cnt_q       <= '0;
`endif
    end else begin
      // First cycle after reset only samples history, so a held input is not an edge.
      armed_q     <= 1'b1;
      mh_q        <= move_h;
      mv_q        <= move_v;
      cf_q        <= confirm;
      moved_q     <= 1'b0;
      blocked_q   <= 1'b0;
      sel_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (edge_h | edge_v) begin
            if (no_nb) begin
              blocked_q <= 1'b1;
            end else begin
              cand_row_q <= nb_row_d;
              cand_col_q <= nb_col_d;
              axis_h_q   <= edge_h;
              dir_q      <= direction;
              state_q    <= SCAN;
`ifdef CURSOR_WRAP_EN
              cnt_q      <= 5'd1;
`endif
            end
          end else if (edge_c) begin
            if (cur_empty) begin
              sel_row_q   <= cur_row_q;
              sel_col_q   <= cur_col_q;
              sel_valid_q <= 1'b1;
            end else begin
              blocked_q <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (cand_empty) begin
            cur_row_q <= cand_row_q;
            cur_col_q <= cand_col_q;
            moved_q   <= 1'b1;
            state_q   <= IDLE;
          end else if (stop_d) begin
            blocked_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cand_row_q <= nb_row_d;
            cand_col_q <= nb_col_d;
`ifdef CURSOR_WRAP_EN
            cnt_q      <= cnt_q + 5'd1;
`endif
          end
        end
      endcase
    end
  end

  assign cur_row   = cur_row_q;
  assign cur_col   = cur_col_q;
  assign sel_row   = sel_row_q;
  assign sel_col   = sel_col_q;
  assign busy      = (state_q == SCAN);
  assign moved     = moved_q;
  assign blocked   = blocked_q;
  assign sel_valid = sel_valid_q;

endmodule
